// File: rtl/debug_proto_pkg.sv
// Shared definitions for the UART debug protocol: command bytes, pipeline dump
// size and the host FSM state encoding. The optional SEND_CKS state only exists
// when DEBUG_HOST_CHECKSUM_EN is defined.
package debug_proto_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int unsigned SEG_ID_EX   = 144;
  localparam int unsigned SEG_EX_MEM  = 32;
  localparam int unsigned SEG_MEM_WB  = 48;
  localparam int unsigned SEG_WB_ID   = 40;
  localparam int unsigned SEG_CONTROL = 24;
  localparam int unsigned DUMP_BITS   = SEG_ID_EX + SEG_EX_MEM + SEG_MEM_WB
                                      + SEG_WB_ID + SEG_CONTROL;
  localparam int unsigned PIPE_DUMP_BYTES = DUMP_BITS / 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_LCMD,
    ST_SEND_CNT,
    ST_FETCH,
    ST_SEND_W,
`ifdef DEBUG_HOST_CHECKSUM_EN
    ST_SEND_CKS,
`endif
    ST_SEND_EXEC,
    ST_WAIT_TX,
    ST_COLLECT,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/debug_host_txseq.sv
// Byte-send handshake for debug_host: registers the byte, emits a one-cycle
// start pulse, then holds the return state until the transmitter reports done.
module debug_host_txseq
  import debug_proto_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_req,
  input  logic [NB_DATA-1:0] i_byte,
  input  state_t             i_ret,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_resume,
  output state_t             o_ret
);

  logic [NB_DATA-1:0] data_q, data_d;
  logic               start_q, start_d;
  logic               wait_q, wait_d;
  state_t             ret_q, ret_d;

  always_comb begin
    data_d   = data_q;
    start_d  = 1'b0;
    wait_d   = wait_q;
    ret_d    = ret_q;
    o_resume = wait_q & i_tx_done;
    if (o_resume) begin
      wait_d = 1'b0;
    end
    if (i_req) begin
      data_d  = i_byte;
      start_d = 1'b1;
      wait_d  = 1'b1;
      ret_d   = i_ret;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      start_q <= 1'b0;
      wait_q  <= 1'b0;
      ret_q   <= ST_IDLE;
    end else begin
      data_q  <= data_d;
      start_q <= start_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_start = start_q;
  assign o_ret      = ret_q;

endmodule

// File: rtl/debug_host.sv
// Host-side initiator for the UART debug protocol: loads a ROM image, issues
// run/step, collects the pipeline dump. Define DEBUG_HOST_CHECKSUM_EN to append
// an XOR checksum byte after the instruction words of a non-empty load.
module debug_host
  import debug_proto_pkg::*;
#(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_32       = 32,
  parameter int unsigned NB_ADDR     = 8,
  parameter int unsigned DUMP_BYTES  = PIPE_DUMP_BYTES,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_go,
  input  logic               i_step_mode,
  input  logic [NB_ADDR-1:0] i_n_instr,
  output logic [NB_ADDR-1:0] o_rom_addr,
  input  logic [NB_32-1:0]   i_rom_data,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_byte,
  output logic [5:0]         o_dump_idx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int unsigned        TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);
  localparam logic [5:0]         LAST_IDX  = 6'(DUMP_BYTES - 1);
  localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam state_t ST_AFTER_LOAD = ST_SEND_CKS;
`else
  localparam state_t ST_AFTER_LOAD = ST_SEND_EXEC;
`endif

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [NB_ADDR-1:0]   cnt_q, cnt_d;
  logic [NB_ADDR-1:0]   idx_q, idx_d;
  logic [NB_32-1:0]     shreg_q, shreg_d;
  logic [1:0]           bsel_q, bsel_d;
  logic                 fetch_ph_q, fetch_ph_d;
  logic [5:0]           rcnt_q, rcnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 dv_q, dv_d;
  logic [NB_DATA-1:0]   db_q, db_d;
  logic [5:0]           di_q, di_d;
`ifdef DEBUG_HOST_CHECKSUM_EN
  logic [NB_DATA-1:0]   cks_q, cks_d;
`endif

  logic                 req;
  logic [NB_DATA-1:0]   req_byte;
  state_t               req_ret;
  logic                 tx_resume;
  state_t               tx_ret;

  debug_host_txseq #(
    .NB_DATA (NB_DATA)
  ) u_txseq (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_req      (req),
    .i_byte     (req_byte),
    .i_ret      (req_ret),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_resume   (tx_resume),
    .o_ret      (tx_ret)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    bsel_d     = bsel_q;
    fetch_ph_d = fetch_ph_q;
    rcnt_d     = rcnt_q;
    err_d      = err_q;
    dv_d       = 1'b0;
    db_d       = db_q;
    di_d       = di_q;
`ifdef DEBUG_HOST_CHECKSUM_EN
    cks_d      = cks_q;
`endif
    req        = 1'b0;
    req_byte   = '0;
    req_ret    = ST_IDLE;
    // The idle counter only runs inside COLLECT, so entry there starts it at 0.
    tmo_d      = (state_q == ST_COLLECT && !i_rx_done) ? tmo_q + 1'b1 : '0;

    case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          mode_d     = i_step_mode;
          cnt_d      = i_n_instr;
          idx_d      = '0;
          bsel_d     = '0;
          fetch_ph_d = 1'b0;
          rcnt_d     = '0;
          err_d      = 1'b0;
`ifdef DEBUG_HOST_CHECKSUM_EN
          cks_d      = '0;
`endif
          state_d    = (i_n_instr != '0) ? ST_SEND_LCMD : ST_SEND_EXEC;
        end
      end
      ST_SEND_LCMD: begin
        req      = 1'b1;
        req_byte = NB_DATA'(CMD_LOAD);
        req_ret  = ST_SEND_CNT;
        state_d  = ST_WAIT_TX;
      end
      ST_SEND_CNT: begin
        req      = 1'b1;
        req_byte = NB_DATA'(cnt_q);
        req_ret  = ST_FETCH;
        state_d  = ST_WAIT_TX;
      end
      ST_FETCH: begin
        // First cycle presents the address; the ROM word is valid on the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          shreg_d    = i_rom_data;
          bsel_d     = '0;
          state_d    = ST_SEND_W;
        end
      end
      ST_SEND_W: begin
        req      = 1'b1;
        req_byte = shreg_q[NB_32-1 -: NB_DATA];
        shreg_d  = shreg_q << NB_DATA;
        bsel_d   = bsel_q + 1'b1;
`ifdef DEBUG_HOST_CHECKSUM_EN
        cks_d    = cks_q ^ shreg_q[NB_32-1 -: NB_DATA];
`endif
        if (bsel_q == 2'd3) begin
          if (idx_q == cnt_q - ADDR_ONE) begin
            req_ret = ST_AFTER_LOAD;
          end else begin
            idx_d   = idx_q + ADDR_ONE;
            req_ret = ST_FETCH;
          end
        end else begin
          req_ret = ST_SEND_W;
        end
        state_d  = ST_WAIT_TX;
      end
`ifdef DEBUG_HOST_CHECKSUM_EN
      ST_SEND_CKS: begin
        req      = 1'b1;
        req_byte = cks_q;
        req_ret  = ST_SEND_EXEC;
        state_d  = ST_WAIT_TX;
      end
`endif
      ST_SEND_EXEC: begin
        req      = 1'b1;
        req_byte = mode_q ? NB_DATA'(CMD_STEP) : NB_DATA'(CMD_RUN);
        req_ret  = ST_COLLECT;
        rcnt_d   = '0;
        state_d  = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_resume) begin
          state_d = tx_ret;
        end
      end
      ST_COLLECT: begin
        if (i_rx_done) begin
          dv_d   = 1'b1;
          db_d   = i_rx_data;
          di_d   = rcnt_q;
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end else if (tmo_q + 1'b1 == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (i_rx_done && state_q != ST_COLLECT) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      bsel_q     <= '0;
      fetch_ph_q <= 1'b0;
      rcnt_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      dv_q       <= 1'b0;
      db_q       <= '0;
      di_q       <= '0;
`ifdef DEBUG_HOST_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      bsel_q     <= bsel_d;
      fetch_ph_q <= fetch_ph_d;
      rcnt_q     <= rcnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      dv_q       <= dv_d;
      db_q       <= db_d;
      di_q       <= di_d;
`ifdef DEBUG_HOST_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  assign o_rom_addr   = idx_q;
  assign o_dump_valid = dv_q;
  assign o_dump_byte  = db_q;
  assign o_dump_idx   = di_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_err        = err_q;

endmodule

// File: tb/tb_debug_host.sv
// Self-checking bench for debug_host: UART TX/RX and ROM models around the DUT,
// expected frames and dumps computed from the protocol rules.
module tb_debug_host;

  localparam int TMO  = 100;
  localparam int DUMP = 36;

  logic        clk = 1'b0;
  logic        i_reset, i_go, i_step_mode;
  logic [7:0]  i_n_instr, o_rom_addr;
  logic [31:0] i_rom_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, i_tx_done;
  logic [7:0]  i_rx_data;
  logic        i_rx_done, o_dump_valid;
  logic [7:0]  o_dump_byte;
  logic [5:0]  o_dump_idx;
  logic        o_busy, o_done, o_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom [256];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_frame[$];
  int          tx_dones = 0;
  int          hold_at = -1;
  int          proto_viol = 0;
  int          max_tx_gap = 5;
  int          resp_gap;
  int          addr_max = 0;

  debug_host #(
    .NB_DATA     (8),
    .NB_32       (32),
    .NB_ADDR     (8),
    .DUMP_BYTES  (DUMP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_go         (i_go),
    .i_step_mode  (i_step_mode),
    .i_n_instr    (i_n_instr),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (i_tx_done),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_dump_valid (o_dump_valid),
    .o_dump_byte  (o_dump_byte),
    .o_dump_idx   (o_dump_idx),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) i_rom_data <= rom[o_rom_addr];

  always @(negedge clk) if (int'(o_rom_addr) > addr_max) addr_max = int'(o_rom_addr);

  // UART transmitter model: logs each byte, answers with a done pulse after a
  // random delay, and counts any start pulse seen while a byte is in flight.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (o_tx_start && !i_reset) begin
        tx_log.push_back(o_tx_data);
        @(posedge clk); #1;
        if (o_tx_start) proto_viol++;
        resp_gap = $urandom_range(0, max_tx_gap);
        for (int k = 0; k < resp_gap && !i_reset; k++) begin
          @(posedge clk); #1;
          if (o_tx_start) proto_viol++;
        end
        while (hold_at == tx_log.size() && !i_reset) begin
          @(posedge clk); #1;
          if (o_tx_start) proto_viol++;
        end
        if (!i_reset) begin
          i_tx_done = 1'b1;
          @(posedge clk); #1;
          i_tx_done = 1'b0;
          tx_dones++;
          if (o_tx_start) proto_viol++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference frame: load header, words MSB first, optional XOR, command.
  task automatic build_frame(input int n, input bit step);
    logic [7:0] cks;
    logic [7:0] b;
    exp_frame.delete();
    cks = 8'h00;
    if (n != 0) begin
      exp_frame.push_back(8'h4C);
      exp_frame.push_back(8'(n));
      for (int w = 0; w < n; w++) begin
        for (int s = 3; s >= 0; s--) begin
          b = 8'(rom[w] >> (8 * s));
          exp_frame.push_back(b);
          cks = cks ^ b;
        end
      end
`ifdef DEBUG_HOST_CHECKSUM_EN
      exp_frame.push_back(cks);
`endif
    end
    exp_frame.push_back(step ? 8'h53 : 8'h52);
  endtask

  task automatic start_go(input int n, input bit step);
    tx_log.delete();
    tx_dones = 0;
    build_frame(n, step);
    i_n_instr   = 8'(n);
    i_step_mode = step;
    i_go        = 1'b1;
    @(posedge clk); #1;
    i_go        = 1'b0;
    i_n_instr   = $urandom;
    i_step_mode = $urandom;
    addr_max    = 0;
    checks++;
    if (o_busy !== 1'b1 || o_err !== 1'b0)
      $display("FAIL go_accept: busy=%0b err=%0b, required busy=1 err=0", o_busy, o_err);
    if (o_busy !== 1'b1 || o_err !== 1'b0) errors++;
  endtask

  task automatic wait_frame(input string name);
    int budget;
    int cyc;
    budget = 16 * exp_frame.size() + 100;
    for (cyc = 0; tx_dones < exp_frame.size() && cyc < budget; cyc++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (tx_log.size() != exp_frame.size()) begin
      errors++;
      $display("FAIL %s frame_len: got %0d bytes, required %0d", name, tx_log.size(), exp_frame.size());
    end else begin
      for (int i = 0; i < exp_frame.size(); i++) begin
        checks++;
        if (tx_log[i] !== exp_frame[i]) begin
          errors++;
          $display("FAIL %s tx[%0d]: got %02h, required %02h", name, i, tx_log[i], exp_frame[i]);
        end
      end
    end
  endtask

  task automatic collect_dump(input string name, input bit seq);
    logic [7:0] b;
    int gap;
    for (int k = 0; k < DUMP; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      b = seq ? 8'(k) : 8'($urandom);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(posedge clk); #1;
      i_rx_done = 1'b0;
      checks++;
      if (o_dump_valid !== 1'b1 || o_dump_byte !== b || o_dump_idx !== 6'(k)) begin
        errors++;
        $display("FAIL %s dump[%0d]: got v=%0b byte=%02h idx=%0d, required v=1 byte=%02h idx=%0d",
                 name, k, o_dump_valid, o_dump_byte, o_dump_idx, b, k);
      end
      checks++;
      if (o_done !== 1'(k == DUMP - 1)) begin
        errors++;
        $display("FAIL %s done_at[%0d]: got %0b, required %0b", name, k, o_done, (k == DUMP - 1));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle: busy=%0b done=%0b, required 0 0", name, o_busy, o_done);
    end
  endtask

  task automatic check_rom_span(input string name, input int n);
    int want;
    want = (n == 0) ? 0 : n - 1;
    checks++;
    if (addr_max != want || int'(o_rom_addr) != want) begin
      errors++;
      $display("FAIL %s rom_addr: max=%0d final=%0d, required %0d", name, addr_max, o_rom_addr, want);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({o_rom_addr, o_tx_data, o_tx_start, o_dump_valid, o_dump_byte, o_dump_idx,
         o_busy, o_done, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b start=%0b err=%0b, required 0 0 0", o_busy, o_tx_start, o_err);
    end
  endtask

  task automatic test_load_run();
    logic [7:0] lit[$];
    rom[0] = 32'h20010005;
    rom[1] = 32'hAC010004;
`ifdef DEBUG_HOST_CHECKSUM_EN
    lit = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h8D, 8'h52};
`else
    lit = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h52};
`endif
    start_go(2, 1'b0);
    exp_frame = lit;
    wait_frame("load_run");
    collect_dump("load_run", 1'b1);
    check_rom_span("load_run", 2);
  endtask

  task automatic test_step_noload();
    start_go(0, 1'b1);
    wait_frame("step_noload");
    collect_dump("step_noload", 1'b0);
    check_rom_span("step_noload", 0);
  endtask

  task automatic test_random();
    int n;
    bit step;
    for (int s = 0; s < 5; s++) begin
      n = (s == 4) ? 0 : $urandom_range(1, 6);
      step = 1'($urandom);
      for (int w = 0; w < 256; w++) rom[w] = $urandom;
      start_go(n, step);
      wait_frame("random");
      collect_dump("random", 1'b0);
      check_rom_span("random", n);
    end
  endtask

  task automatic test_max_count();
    max_tx_gap = 0;
    for (int w = 0; w < 256; w++) rom[w] = $urandom;
    start_go(255, 1'b0);
    wait_frame("max_count");
    collect_dump("max_count", 1'b0);
    check_rom_span("max_count", 255);
    max_tx_gap = 5;
  endtask

  task automatic test_timeout();
    int cyc;
    bit saw_done;
    start_go(0, 1'b0);
    wait_frame("timeout");
    for (int k = 0; k < 10; k++) begin
      i_rx_data = 8'($urandom);
      i_rx_done = 1'b1;
      @(posedge clk); #1;
      i_rx_done = 1'b0;
    end
    saw_done = 1'b0;
    for (cyc = 1; cyc <= TMO + 20; cyc++) begin
      @(posedge clk); #1;
      if (o_done) saw_done = 1'b1;
      if (o_err) break;
    end
    checks++;
    if (cyc != TMO) begin
      errors++;
      $display("FAIL timeout_latency: err after %0d cycles, required %0d", cyc, TMO);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL timeout_no_done: got done=1, required 0");
    end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: busy=%0b err=%0b, required busy=0 err=1", o_busy, o_err);
    end
    start_go(1, 1'b1);
    wait_frame("after_timeout");
    collect_dump("after_timeout", 1'b0);
  endtask

  task automatic test_stray_rx();
    int cyc;
    i_rx_data = 8'hA5;
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_dump_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: err=%0b valid=%0b busy=%0b, required 1 0 0", o_err, o_dump_valid, o_busy);
    end
    start_go(1, 1'b0);
    for (cyc = 0; tx_dones < 1 && cyc < 200; cyc++) begin
      @(posedge clk); #1;
    end
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_dump_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL stray_load: err=%0b valid=%0b busy=%0b, required 1 0 1", o_err, o_dump_valid, o_busy);
    end
    wait_frame("stray_rx");
    collect_dump("stray_rx", 1'b0);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky: err=%0b, required 1", o_err);
    end
  endtask

  task automatic test_handshake();
    for (int w = 0; w < 2; w++) rom[w] = $urandom;
    hold_at = 1;
    start_go(2, 1'b0);
    repeat (250) @(posedge clk);
    #1;
    i_n_instr = 8'd0; i_step_mode = 1'b1; i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    repeat (249) @(posedge clk);
    #1;
    checks++;
    if (tx_log.size() != 1 || proto_viol != 0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL handshake_hold: bytes=%0d viol=%0d busy=%0b, required 1 0 1", tx_log.size(), proto_viol, o_busy);
    end
    hold_at = -1;
    wait_frame("handshake");
    collect_dump("handshake", 1'b0);
  endtask

  task automatic test_reset_midload();
    int cyc;
    rom[0] = $urandom;
    rom[1] = $urandom;
    hold_at = 5;
    start_go(2, 1'b0);
    for (cyc = 0; tx_log.size() < 5 && cyc < 200; cyc++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #3 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_rom_addr, o_tx_data, o_tx_start, o_dump_valid, o_dump_byte, o_dump_idx,
         o_busy, o_done, o_err} !== '0 || tx_log.size() != 5) begin
      errors++;
      $display("FAIL reset_midload: busy=%0b addr=%0d data=%02h bytes=%0d, required all outputs 0 and 5 bytes",
               o_busy, o_rom_addr, o_tx_data, tx_log.size());
    end
    hold_at = -1;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tx_log.size() != 5 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resend: bytes=%0d busy=%0b, required 5 0", tx_log.size(), o_busy);
    end
    start_go(2, 1'b0);
    wait_frame("reset_restart");
    collect_dump("reset_restart", 1'b0);
    checks++;
    if (proto_viol != 0) begin
      errors++;
      $display("FAIL start_pulse_rule: violations=%0d, required 0", proto_viol);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_go = 1'b0;
    i_step_mode = 1'b0;
    i_n_instr = '0;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    for (int w = 0; w < 256; w++) rom[w] = $urandom;
    test_reset();
    test_load_run();
    test_step_noload();
    test_random();
    test_max_count();
    test_timeout();
    test_stray_rx();
    test_handshake();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
